// File: rtl/clk_mon_pkg.sv
// Shared types and default sizes for the slow-clock tick monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2,
    STALL = 2'd3
  } monState_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_PERIOD_W    = 8;
  localparam int DEF_TIMEOUT     = 64;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings a slow level into the clk domain and flags its rising edges.
// Reusable for any slow input that must be observed low before a rise counts.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [SYNC_STAGES:0]   r_armed;

  // r_armed tracks which stages hold real samples, so reset zeros never look like a low level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_armed <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev  <= r_sync[SYNC_STAGES-1];
      r_armed <= {r_armed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign rise_pulse = r_sync[SYNC_STAGES-1] & ~r_prev & r_armed[SYNC_STAGES];

endmodule

// File: rtl/clock_tick_monitor.sv
// Converts a divided clock into single-cycle ticks, counts them, measures the
// tick period in clk cycles and flags a stalled slow clock.
module clock_tick_monitor
  import clk_mon_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PERIOD_W    = DEF_PERIOD_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  input  logic                clk_slow,
  output logic                tick,
  output logic [CNT_W-1:0]    tick_count,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stalled
);

  localparam logic [PERIOD_W-1:0] RUN_MAX   = '1;
  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);

  logic                w_rise;
  logic                r_tickRaw;
  logic                w_tickAcc;
  logic                w_timeout;
  logic [PERIOD_W-1:0] r_runCnt;
  logic [PERIOD_W-1:0] r_period;
  logic [CNT_W-1:0]    r_tickCount;
  monState_t           r_state;
  monState_t           w_nextState;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_syncEdge (
    .clk       (clk),
    .rst       (rst),
    .async_in  (clk_slow),
    .rise_pulse(w_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tickRaw <= 1'b0;
    else     r_tickRaw <= w_rise;
  end

  // The synchronizer never stops, so gating only the visible tick keeps re-enable glitch-free
  assign tick      = r_tickRaw & enable;
  assign w_tickAcc = tick & ~clear;
  assign w_timeout = (r_runCnt == TIMEOUT_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_runCnt    <= '0;
      r_tickCount <= '0;
      r_period    <= '0;
    end else if (clear) begin
      r_runCnt    <= '0;
      r_tickCount <= '0;
      r_period    <= '0;
    end else if (enable) begin
      if (w_tickAcc) begin
        r_runCnt    <= PERIOD_W'(1);
        r_tickCount <= r_tickCount + CNT_W'(1);
        if (r_state == FIRST || r_state == RUN) r_period <= r_runCnt;
      end else if (r_runCnt != RUN_MAX) begin
        r_runCnt <= r_runCnt + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_state <= IDLE;
    else if (clear) r_state <= IDLE;
    else            r_state <= w_nextState;
  end

  // A tick arriving in the same cycle as the timeout wins over the stall
  always_comb begin
    w_nextState = r_state;
    if (!enable) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:       if (w_tickAcc) w_nextState = FIRST;
        FIRST, RUN: begin
          if (w_tickAcc)      w_nextState = RUN;
          else if (w_timeout) w_nextState = STALL;
        end
        STALL:      if (w_tickAcc) w_nextState = FIRST;
        default:    w_nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    period_valid = 1'b0;
    stalled      = 1'b0;
    if (enable) begin
      period_valid = (r_state == RUN);
      stalled      = (r_state == STALL);
    end
  end

  assign tick_count = r_tickCount;
  assign period     = r_period;

endmodule

// File: doc/clock_tick_monitor.md
Name: clock_tick_monitor

Overview:
- Sits directly downstream of static_clock_divider.
- Takes the divider's clk_out as a data input (clk_slow) and brings it into the clk domain through a synchronizer.
- Turns each rising edge of clk_slow into a single-cycle tick pulse, counts ticks, and measures the tick period in clk cycles.
- Flags a stalled slow clock; slow-rate logic consumes tick instead of using clk_out as a clock.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the clk_slow synchronizer; legal values are 2 or more.
- CNT_W, 16, width of tick_count.
- PERIOD_W, 8, width of the period measurement and the internal run counter.
- TIMEOUT, 64, clk cycles without a tick before stalled asserts; legal range is 2 to 2^PERIOD_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  when low: tick is suppressed, counters hold, and the FSM is forced to IDLE.
- clear  in  1  synchronous clear of the counters and the FSM.
- clk_slow  in  1  divided clock (the static_clock_divider clk_out), treated as a level.
- tick  out  1  one-cycle pulse per rising edge of clk_slow.
- tick_count  out  CNT_W  number of ticks since reset or clear; wraps modulo 2^CNT_W.
- period  out  PERIOD_W  clk cycles between the last two ticks; saturates at all-ones.
- period_valid  out  1  period holds a real measurement.
- stalled  out  1  no tick seen for TIMEOUT cycles.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: all synchronizer flops 0, previous-sample flop 0, tick 0, tick_count 0, period 0, period_valid 0, stalled 0, run counter 0, FSM in IDLE.
- Synchronizer: SYNC_STAGES flops, then a previous-sample flop. The rising-edge condition is the synchronizer output high while the previous sample is low.
- tick is registered. If clk edge k is the first edge to sample clk_slow=1, tick is high for exactly the cycle after edge k+SYNC_STAGES.
- The synchronizer runs regardless of enable, so re-enabling never produces a false edge.
- Run counter:
  - Reloads to 1 in the cycle tick is high.
  - Otherwise increments each cycle and saturates at 2^PERIOD_W-1.
  - It therefore equals the clk-cycle distance since the last tick.
- FSM states: IDLE, FIRST, RUN, STALL.
  - IDLE: on tick, go to FIRST; period not updated.
  - FIRST: on tick, latch period = run counter value, set period_valid=1, go to RUN. If the run counter reaches TIMEOUT first, go to STALL.
  - RUN: on tick, latch period and stay in RUN. If the run counter reaches TIMEOUT, go to STALL.
  - STALL: on entry, stalled=1 and period_valid=0. On the next tick, stalled=0 and go to FIRST; the period across a stall is never reported.
- tick_count increments on every tick while enable=1 and clear=0, and wraps from all-ones to 0 with no flag.
- enable=0:
  - tick forced to 0 and tick_count held.
  - FSM forced to IDLE, period_valid=0, stalled=0.
  - period keeps its last value.
- Priority: rst > clear > enable > tick.
- clear=1 for one cycle:
  - Next cycle: tick_count=0, period=0, period_valid=0, stalled=0, FSM in IDLE.
  - A tick coinciding with clear is dropped.
- A tick coinciding with run counter = TIMEOUT counts as a tick; there is no stall.
- An asynchronous rst asserted mid-operation returns all outputs to reset values immediately. No tick is generated on release, even if clk_slow is high: the edge detector requires a low sample first.
- Expected periods with a phase-locked static_clock_divider input: 2^N for divider N=1..3. Jitter of ±1 cycle is allowed only for a truly asynchronous clk_slow.

Decomposition:
- Package clk_mon_pkg:
  - FSM state enum (IDLE, FIRST, RUN, STALL).
  - Default-width constants.
- One sub-module, sync_edge_detect:
  - Parameter SYNC_STAGES.
  - Inputs clk, rst, async_in; output rise_pulse.
  - Contains the synchronizer chain and the edge flop; reusable for other slow inputs.

Test Plan:
- Feed from static_clock_divider N=1, enable=1, after rst release -> first tick 2+SYNC_STAGES cycles after clk_slow first goes high; period_valid rises at the second tick with period=2; tick_count=10 after 10 ticks.
- Swap the source to N=2, then N=3 -> period=4, then period=8; tick is never high for 2 consecutive cycles.
- Hold clk_slow low for 64 cycles after the second tick -> stalled=1 and period_valid=0 at run counter=64. Resume -> stalled=0 at the next tick; period_valid returns only after the following tick.
- Pulse clear in the same cycle as a tick (N=2 source) -> tick_count=0, period=0, FSM in IDLE; the dropped tick is not counted.
- Deassert enable for 20 cycles with N=1 running -> tick=0 and tick_count frozen throughout. Re-enable -> no spurious tick; counting resumes at the next real edge.
- CNT_W=4, run 17 ticks -> tick_count reaches 15, then 0, then 1.
- Assert rst asynchronously with clk_slow high mid-run -> all outputs 0 immediately. After release, no tick until clk_slow is seen low and then high.
